// File: rtl/count_snapshot_fifo.sv
// count_snapshot_fifo
//   Captures snapshots of a free-running WIDTH-bit tick counter into a
//   DEPTH-entry first-word-fall-through FIFO. Each entry holds the captured
//   count and its modular delta from the previous accepted capture. Counter
//   wrap-arounds are counted (saturating) and dropped captures are flagged.
//
// Ports:
//   clock       rising-edge clock
//   reset       asynchronous active-high reset
//   count_in    upstream counter value, sampled every clock
//   capture     push a snapshot of count_in at this edge
//   clear       synchronous flush of FIFO and all status
//   out_ready   sink accepts the head entry
//   out_valid   FIFO non-empty
//   out_count   head entry's captured count (0 when empty)
//   out_delta   head entry's delta from previous accepted capture (0 when empty)
//   level       number of occupied entries, 0..DEPTH
//   wrap_count  saturating count of detected counter wraps
//   overflow    sticky, a capture was dropped because the FIFO was full
module count_snapshot_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           count_in,
    input  logic                       capture,
    input  logic                       clear,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_count,
    output logic [WIDTH-1:0]           out_delta,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic [WIDTH-1:0]           wrap_count,
    output logic                       overflow
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] cnt_mem_q [DEPTH];
    logic [WIDTH-1:0] cnt_mem_d [DEPTH];
    logic [WIDTH-1:0] dlt_mem_q [DEPTH];
    logic [WIDTH-1:0] dlt_mem_d [DEPTH];

    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [WIDTH-1:0] last_cap_q, last_cap_d;
    logic [WIDTH-1:0] prev_count_q, prev_count_d;
    logic             prev_ok_q, prev_ok_d;
    logic [WIDTH-1:0] wrap_count_q, wrap_count_d;
    logic             overflow_q, overflow_d;

    logic not_empty;
    logic full;
    logic pop;
    logic push;
    logic wrap_seen;

    assign not_empty = (level_q != '0);
    assign full      = (level_q == LW'(DEPTH));

    // clear wins over both push and pop at the same edge
    assign pop       = not_empty && out_ready && !clear;
    // a full FIFO still accepts a capture when the head leaves at the same edge
    assign push      = capture && !clear && (!full || pop);
    assign wrap_seen = prev_ok_q && (count_in < prev_count_q);

    always_comb begin
        cnt_mem_d    = cnt_mem_q;
        dlt_mem_d    = dlt_mem_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        level_d      = level_q;
        last_cap_d   = last_cap_q;
        prev_count_d = count_in;
        prev_ok_d    = 1'b1;
        wrap_count_d = wrap_count_q;
        overflow_d   = overflow_q;

        if (clear) begin
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            level_d      = '0;
            last_cap_d   = '0;
            prev_ok_d    = 1'b0;
            wrap_count_d = '0;
            overflow_d   = 1'b0;
        end else begin
            if (wrap_seen && (wrap_count_q != '1)) begin
                wrap_count_d = wrap_count_q + WIDTH'(1);
            end

            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end

            if (push) begin
                cnt_mem_d[wr_ptr_q] = count_in;
                dlt_mem_d[wr_ptr_q] = count_in - last_cap_q;
                wr_ptr_d            = wr_ptr_q + PW'(1);
                last_cap_d          = count_in;
            end else if (capture) begin
                // dropped: last_cap is kept so the next delta spans the gap
                overflow_d = 1'b1;
            end

            if (push && !pop) begin
                level_d = level_q + LW'(1);
            end else if (pop && !push) begin
                level_d = level_q - LW'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                cnt_mem_q[i] <= '0;
                dlt_mem_q[i] <= '0;
            end
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            level_q      <= '0;
            last_cap_q   <= '0;
            prev_count_q <= '0;
            prev_ok_q    <= 1'b0;
            wrap_count_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            cnt_mem_q    <= cnt_mem_d;
            dlt_mem_q    <= dlt_mem_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            level_q      <= level_d;
            last_cap_q   <= last_cap_d;
            prev_count_q <= prev_count_d;
            prev_ok_q    <= prev_ok_d;
            wrap_count_q <= wrap_count_d;
            overflow_q   <= overflow_d;
        end
    end

    // Head is masked with not_empty so stale storage never shows on an empty FIFO.
    always_comb begin
        out_valid  = not_empty;
        out_count  = not_empty ? cnt_mem_q[rd_ptr_q] : '0;
        out_delta  = not_empty ? dlt_mem_q[rd_ptr_q] : '0;
        level      = level_q;
        wrap_count = wrap_count_q;
        overflow   = overflow_q;
    end

endmodule

// File: tb/tb_count_snapshot_fifo.sv
// tb_count_snapshot_fifo
//   Self-checking bench for count_snapshot_fifo (WIDTH=8, DEPTH=4). Directed
//   vector table, hand-written corner sequences and randomized traffic, all
//   compared against a queue-based reference model.
module tb_count_snapshot_fifo;

    localparam int unsigned DEPTH = 4;

    logic       clock;
    logic       reset;
    logic [7:0] count_in;
    logic       capture;
    logic       clear;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_count;
    logic [7:0] out_delta;
    logic [2:0] level;
    logic [7:0] wrap_count;
    logic       overflow;

    count_snapshot_fifo #(
        .WIDTH(8),
        .DEPTH(DEPTH)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .count_in  (count_in),
        .capture   (capture),
        .clear     (clear),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_count (out_count),
        .out_delta (out_delta),
        .level     (level),
        .wrap_count(wrap_count),
        .overflow  (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vectors = 0;
    int n_checks  = 0;
    int n_fail    = 0;

    // Reference model: plain queues plus the status scalars.
    logic [7:0] m_cnt[$];
    logic [7:0] m_dlt[$];
    logic [7:0] m_last;
    logic [7:0] m_prev;
    logic       m_pok;
    int         m_wraps;
    logic       m_ovf;

    typedef struct {
        logic [7:0] cnt;
        logic       cap;
        logic       rdy;
        logic       clr;
        logic       ev;
        logic [7:0] ec;
        logic [7:0] ed;
        logic [2:0] el;
        logic [7:0] ew;
        logic       eo;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt.delete();
        m_dlt.delete();
        m_last  = 8'd0;
        m_prev  = 8'd0;
        m_pok   = 1'b0;
        m_wraps = 0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_edge(input logic [7:0] cnt, input logic cap, input logic rdy,
                              input logic clr);
        bit do_pop;
        bit room;
        if (clr) begin
            m_cnt.delete();
            m_dlt.delete();
            m_wraps = 0;
            m_ovf   = 1'b0;
            m_last  = 8'd0;
            m_pok   = 1'b0;
            m_prev  = cnt;
            return;
        end
        do_pop = (m_cnt.size() > 0) && rdy;
        room   = (m_cnt.size() < DEPTH) || do_pop;
        if (m_pok && (cnt < m_prev) && (m_wraps < 255)) m_wraps++;
        m_prev = cnt;
        m_pok  = 1'b1;
        if (do_pop) begin
            void'(m_cnt.pop_front());
            void'(m_dlt.pop_front());
        end
        if (cap) begin
            if (room) begin
                m_cnt.push_back(cnt);
                m_dlt.push_back(8'(cnt - m_last));
                m_last = cnt;
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic check_model(input string tag);
        bit ne;
        ne = (m_cnt.size() > 0);
        check({tag, ".valid"}, 32'(out_valid), 32'(ne));
        check({tag, ".count"}, 32'(out_count), ne ? 32'(m_cnt[0]) : 32'd0);
        check({tag, ".delta"}, 32'(out_delta), ne ? 32'(m_dlt[0]) : 32'd0);
        check({tag, ".level"}, 32'(level), 32'(m_cnt.size()));
        check({tag, ".wrap"}, 32'(wrap_count), 32'(m_wraps));
        check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    endtask

    // Drive inputs, take one rising edge, advance the model, compare 1 time unit later.
    task automatic step(input string tag, input logic [7:0] cnt, input logic cap,
                        input logic rdy, input logic clr);
        count_in  = cnt;
        capture   = cap;
        out_ready = rdy;
        clear     = clr;
        @(posedge clock);
        model_edge(cnt, cap, rdy, clr);
        #1;
        n_vectors++;
        check_model(tag);
    endtask

    task automatic add(input logic [7:0] cnt, input logic cap, input logic rdy, input logic clr,
                       input logic ev, input logic [7:0] ec, input logic [7:0] ed,
                       input logic [2:0] el, input logic [7:0] ew, input logic eo);
        vec_t v;
        v.cnt = cnt; v.cap = cap; v.rdy = rdy; v.clr = clr;
        v.ev = ev; v.ec = ec; v.ed = ed; v.el = el; v.ew = ew; v.eo = eo;
        tbl.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] ctr;
        int         rdy_pct;

        //      cnt  cap  rdy  clr | valid count delta lvl wrap ovf
        add(8'd5,   1, 0, 0,   1, 8'd5,   8'd5,   3'd1, 8'd0, 0);
        add(8'd6,   0, 0, 0,   1, 8'd5,   8'd5,   3'd1, 8'd0, 0);
        add(8'd12,  1, 0, 0,   1, 8'd5,   8'd5,   3'd2, 8'd0, 0);
        add(8'd13,  0, 1, 0,   1, 8'd12,  8'd7,   3'd1, 8'd0, 0);
        add(8'd14,  0, 1, 0,   0, 8'd0,   8'd0,   3'd0, 8'd0, 0);
        add(8'd10,  1, 0, 0,   1, 8'd10,  8'd254, 3'd1, 8'd1, 0);
        add(8'd11,  1, 0, 0,   1, 8'd10,  8'd254, 3'd2, 8'd1, 0);
        add(8'd12,  1, 0, 0,   1, 8'd10,  8'd254, 3'd3, 8'd1, 0);
        add(8'd13,  1, 0, 0,   1, 8'd10,  8'd254, 3'd4, 8'd1, 0);
        add(8'd14,  1, 0, 0,   1, 8'd10,  8'd254, 3'd4, 8'd1, 1);
        add(8'd15,  0, 1, 0,   1, 8'd11,  8'd1,   3'd3, 8'd1, 1);
        add(8'd16,  0, 1, 0,   1, 8'd12,  8'd1,   3'd2, 8'd1, 1);
        add(8'd17,  0, 1, 0,   1, 8'd13,  8'd1,   3'd1, 8'd1, 1);
        add(8'd18,  0, 1, 0,   0, 8'd0,   8'd0,   3'd0, 8'd1, 1);
        add(8'd20,  1, 0, 0,   1, 8'd20,  8'd7,   3'd1, 8'd1, 1);
        add(8'd21,  0, 0, 1,   0, 8'd0,   8'd0,   3'd0, 8'd0, 0);
        add(8'd22,  1, 0, 0,   1, 8'd22,  8'd22,  3'd1, 8'd0, 0);
        add(8'd23,  1, 0, 0,   1, 8'd22,  8'd22,  3'd2, 8'd0, 0);
        add(8'd24,  1, 0, 0,   1, 8'd22,  8'd22,  3'd3, 8'd0, 0);
        add(8'd25,  1, 0, 0,   1, 8'd22,  8'd22,  3'd4, 8'd0, 0);
        add(8'd26,  1, 1, 0,   1, 8'd23,  8'd1,   3'd4, 8'd0, 0);
        add(8'd27,  0, 1, 0,   1, 8'd24,  8'd1,   3'd3, 8'd0, 0);
        add(8'd28,  0, 1, 0,   1, 8'd25,  8'd1,   3'd2, 8'd0, 0);
        add(8'd29,  0, 1, 0,   1, 8'd26,  8'd1,   3'd1, 8'd0, 0);
        add(8'd30,  0, 1, 0,   0, 8'd0,   8'd0,   3'd0, 8'd0, 0);
        add(8'd250, 1, 0, 0,   1, 8'd250, 8'd224, 3'd1, 8'd0, 0);
        add(8'd3,   1, 0, 0,   1, 8'd250, 8'd224, 3'd2, 8'd1, 0);
        add(8'd4,   0, 1, 0,   1, 8'd3,   8'd9,   3'd1, 8'd1, 0);

        // Reset, released between edges
        reset     = 1'b1;
        count_in  = 8'd0;
        capture   = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b0;
        model_reset();
        #23;
        check("reset.valid", 32'(out_valid), 32'd0);
        check("reset.level", 32'(level), 32'd0);
        check("reset.wrap", 32'(wrap_count), 32'd0);
        check("reset.ovf", 32'(overflow), 32'd0);
        check("reset.count", 32'(out_count), 32'd0);
        reset = 1'b0;

        // Directed table
        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("tbl%0d", i), tbl[i].cnt, tbl[i].cap, tbl[i].rdy, tbl[i].clr);
            check($sformatf("tbl%0d.valid", i), 32'(out_valid), 32'(tbl[i].ev));
            check($sformatf("tbl%0d.count", i), 32'(out_count), 32'(tbl[i].ec));
            check($sformatf("tbl%0d.delta", i), 32'(out_delta), 32'(tbl[i].ed));
            check($sformatf("tbl%0d.level", i), 32'(level), 32'(tbl[i].el));
            check($sformatf("tbl%0d.wrap", i), 32'(wrap_count), 32'(tbl[i].ew));
            check($sformatf("tbl%0d.ovf", i), 32'(overflow), 32'(tbl[i].eo));
        end

        // Three full counter periods after clear -> exactly three wraps
        step("wrp_clr", 8'd0, 0, 0, 1);
        for (int i = 1; i <= 768; i++) step("wrp", 8'(i % 256), 0, 0, 0);
        check("wrap3", 32'(wrap_count), 32'd3);
        for (int i = 0; i < 252; i++) begin
            step("sat", 8'd255, 0, 0, 0);
            step("sat", 8'd0, 0, 0, 0);
        end
        check("wrap255", 32'(wrap_count), 32'd255);
        step("sat", 8'd255, 0, 0, 0);
        step("sat", 8'd0, 0, 0, 0);
        check("wrap_sat", 32'(wrap_count), 32'd255);

        // Clear together with capture while 3 entries, overflow and 2 wraps are held
        step("cc", 8'd9, 0, 0, 1);
        step("cc", 8'd10, 1, 0, 0);
        step("cc", 8'd11, 1, 0, 0);
        step("cc", 8'd12, 1, 0, 0);
        step("cc", 8'd13, 1, 0, 0);
        step("cc", 8'd14, 1, 0, 0);
        step("cc", 8'd15, 0, 1, 0);
        step("cc", 8'd5, 0, 0, 0);
        step("cc", 8'd6, 0, 0, 0);
        step("cc", 8'd2, 0, 0, 0);
        check("cc.pre_level", 32'(level), 32'd3);
        check("cc.pre_ovf", 32'(overflow), 32'd1);
        check("cc.pre_wrap", 32'(wrap_count), 32'd2);
        step("cc_clr", 8'd7, 1, 0, 1);
        check("cc.level", 32'(level), 32'd0);
        check("cc.valid", 32'(out_valid), 32'd0);
        check("cc.ovf", 32'(overflow), 32'd0);
        check("cc.wrap", 32'(wrap_count), 32'd0);
        step("cc_after", 8'd8, 0, 0, 0);
        check("cc.no_entry", 32'(level), 32'd0);

        // Asynchronous reset mid-cycle with two entries held
        step("ar", 8'd40, 1, 0, 0);
        step("ar", 8'd41, 1, 0, 0);
        check("ar.pre_level", 32'(level), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check("ar.valid", 32'(out_valid), 32'd0);
        check("ar.count", 32'(out_count), 32'd0);
        check("ar.delta", 32'(out_delta), 32'd0);
        check("ar.level", 32'(level), 32'd0);
        check("ar.wrap", 32'(wrap_count), 32'd0);
        check("ar.ovf", 32'(overflow), 32'd0);
        #2;
        reset = 1'b0;
        step("ar_post", 8'd42, 0, 1, 0);

        // Randomized traffic against the model
        ctr = 8'd0;
        for (int i = 0; i < 2000; i++) begin
            rdy_pct = ((i / 250) % 2 == 0) ? 25 : 80;
            if ($urandom_range(0, 15) == 0) ctr = 8'($urandom);
            else ctr = ctr + 8'd1;
            step("rnd", ctr, 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 99) < rdy_pct), 1'($urandom_range(0, 127) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_fail);
        $finish;
    end

endmodule

// File: doc/count_snapshot_fifo.md
Name: count_snapshot_fifo

Overview:
- Downstream consumer of a free-running WIDTH-bit tick counter, such as a submodule's public 8-bit register that increments every clock.
- On a capture strobe, records the current count and its modular delta from the previous capture into a DEPTH-entry FIFO.
- Drains the FIFO through a valid/ready output port.
- Tracks counter wrap-arounds and flags dropped captures, so the sink can reconstruct elapsed ticks.

Parameters:
- WIDTH, 8: width of count_in, out_count, out_delta and wrap_count.
- DEPTH, 4: FIFO entries. Power of two, minimum 2.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- count_in  in  WIDTH  upstream counter value, sampled every clock.
- capture  in  1  push a snapshot of count_in at this edge.
- clear  in  1  synchronous flush of FIFO and all status.
- out_ready  in  1  sink accepts the head entry.
- out_valid  out  1  FIFO non-empty.
- out_count  out  WIDTH  head entry's captured count.
- out_delta  out  WIDTH  head entry's delta: count minus previous accepted capture, modulo 2^WIDTH.
- level  out  $clog2(DEPTH+1)  number of occupied entries.
- wrap_count  out  WIDTH  number of wraps detected on count_in, saturating.
- overflow  out  1  sticky; a capture was dropped.

Behaviour:
- Reset (asynchronous, active-high) sets all of the following to 0:
  - FIFO pointers and level.
  - out_valid, out_count, out_delta.
  - wrap_count, overflow.
  - last_cap, the last accepted capture value.
  - prev_count and prev_ok, the one-cycle-delayed count_in and its valid bit.
- Reset asserted mid-stream discards all entries immediately. No output glitch to a stale value is permitted after reset releases.
- FIFO output is first-word-fall-through:
  - out_valid = (level != 0).
  - out_count and out_delta are driven combinationally from the head entry.
  - With no entries, out_count and out_delta are 0.
- Pop: occurs at an edge with out_valid && out_ready. The head advances and the next entry appears in the following cycle.
- Push: occurs at an edge with capture=1 and at least one of (level < DEPTH) or (pop in the same cycle).
  - Writes {count_in, count_in - last_cap} at the tail, truncated to WIDTH bits.
  - Updates last_cap to count_in.
  - Latency: capture at edge N makes the entry visible at out_* right after edge N, when the FIFO was empty.
- Full with capture and no pop:
  - Snapshot is dropped; overflow is set and stays set.
  - last_cap is NOT updated, so the next accepted delta spans the dropped capture.
- Full with capture and pop in the same cycle: both occur and level is unchanged.
- Empty with capture and out_ready: push only, since there is no pop while out_valid=0.
- Pointers wrap modulo DEPTH. Level ranges 0..DEPTH.
- Wrap detection runs every cycle:
  - prev_count is loaded with count_in; prev_ok is set to 1.
  - A wrap is counted when prev_ok=1 and count_in < prev_count (unsigned).
  - wrap_count increments by 1 per wrap and saturates at 2^WIDTH-1.
  - No wrap is counted on the first cycle after reset or after clear.
- clear=1 at an edge:
  - Empties the FIFO.
  - Zeroes wrap_count, overflow and last_cap; sets prev_ok to 0.
  - Takes priority over capture and pop at the same edge: neither happens.
  - prev_count still loads count_in.
- No combinational path from capture to out_valid. The only combinational paths are head storage to out_*.

Test Plan:
- Reset, then count_in increments 0,1,2,…; capture at count_in=5 and at count_in=12, with out_ready=0.
  - Required: level=2, out_valid=1, head out_count=5, out_delta=5.
  - After one pop: out_count=12, out_delta=7.
- DEPTH=4, out_ready=0; capture at counts 10,11,12,13, then 14.
  - Required: level=4, overflow=1, entries hold 10..13.
  - Drain all entries, then capture at 20: out_delta=7 (20-13).
- Counter runs 0..255 then back to 0 for three full periods, with no captures.
  - Required: wrap_count=3.
  - Force wrap_count to 255 via 255 wraps, then one more wrap: value stays 255.
- Last capture at 250, counter wraps, capture at 3.
  - Required: out_delta=9, modulo 256.
- FIFO full, capture=1 and out_ready=1 at the same edge.
  - Required: level stays 4, no overflow, new tail holds the current count.
- With 3 entries, overflow=1 and wrap_count=2, assert clear together with capture.
  - Required next cycle: level=0, out_valid=0, overflow=0, wrap_count=0; no entry from that capture.
- Assert reset asynchronously mid-cycle while level=2.
  - Required: out_valid falls to 0 before the next clock edge, and all outputs are 0.
